// File: rtl/link_pkg.sv
// Shared definitions for the optical link controller: packet geometry,
// message/codec op encodings and the Hamming(15,11) syndrome helper.
package link_pkg;

    localparam int MESSAGE_SIZE = 8;
    localparam int PACKET_SIZE  = MESSAGE_SIZE + 3;
    localparam int FRAME_SIZE   = 15;

    typedef enum logic [1:0] {
        MSG_NORMAL   = 2'b00,
        MSG_ACK      = 2'b01,
        MSG_NACK     = 2'b10,
        MSG_EXTENDED = 2'b11
    } msg_type_t;

    typedef enum logic {
        OP_ENCODE = 1'b0,
        OP_DECODE = 1'b1
    } ecc_op_t;

    typedef struct packed {
        logic                    seq;
        msg_type_t               msg_type;
        logic [MESSAGE_SIZE-1:0] message;
    } packet_t;

    // XOR of the 1-based positions of all set bits. On a data-only frame this
    // yields the parity bits; on a received frame it yields the error position.
    function automatic logic [3:0] hamming_syndrome(input logic [FRAME_SIZE-1:0] frame);
        logic [3:0] syn;
        syn = '0;
        for (int i = 0; i < FRAME_SIZE; i++) begin
            if (frame[i]) syn = syn ^ 4'(i + 1);
        end
        return syn;
    endfunction

endpackage

// File: rtl/hamming15_codec.sv
// Hamming(15,11) single-error-correcting codec; one operation per start strobe,
// result registered on the following edge together with a one-cycle irq.
module hamming15_codec
    import link_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   operation,
    input  logic [PACKET_SIZE-1:0] packet,
    input  logic [FRAME_SIZE-1:0]  codeword,
    output logic [FRAME_SIZE-1:0]  frame,
    output logic [PACKET_SIZE-1:0] data,
    output logic                   irq,
    output logic                   correct
);

    logic [FRAME_SIZE-1:0]  enc_base;
    logic [3:0]             enc_parity;
    logic [FRAME_SIZE-1:0]  enc_frame;
    logic [3:0]             dec_syndrome;
    logic [FRAME_SIZE-1:0]  dec_fixed;
    logic [PACKET_SIZE-1:0] dec_data;

    always_comb begin
        // data bits land on the non-power-of-two positions 3,5,6,7,9..15
        enc_base   = {packet[10:4], 1'b0, packet[3:1], 1'b0, packet[0], 2'b00};
        enc_parity = hamming_syndrome(enc_base);
        enc_frame  = enc_base | {7'b0, enc_parity[3], 3'b0, enc_parity[2],
                                 1'b0, enc_parity[1], enc_parity[0]};

        dec_syndrome = hamming_syndrome(codeword);
        dec_fixed    = codeword;
        if (dec_syndrome != 4'd0)
            dec_fixed = codeword ^ (FRAME_SIZE'(1) << (dec_syndrome - 4'd1));
        dec_data = {dec_fixed[14:8], dec_fixed[6:4], dec_fixed[2]};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            frame   <= '0;
            data    <= '0;
            irq     <= 1'b0;
            correct <= 1'b0;
        end else begin
            irq <= start;
            if (start) begin
                if (operation == OP_DECODE) begin
                    data    <= dec_data;
                    correct <= (dec_syndrome == 4'd0);
                end else begin
                    frame <= enc_frame;
                end
            end
        end
    end

endmodule

// File: rtl/link_ctrl_unit.sv
// Link-layer support unit: (N)ACK-first request arbiter, ACK-wait timer and
// Hamming(15,11) codec shared by the TX/RX state machines.
//
// state     | meaning
// ARB_IDLE  | no grant; priority request wins, else normal
// ARB_PRIO  | out_priority held until in_priority drops
// ARB_NORM  | out_normal held until in_normal drops (no preemption)
module link_ctrl_unit
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_priority,
    input  logic                   in_normal,
    output logic                   out_priority,
    output logic                   out_normal,
    input  logic                   timer_restart,
    output logic                   timeout,
    input  logic                   ecc_start,
    input  logic                   ecc_operation,
    input  logic [PACKET_SIZE-1:0] ecc_packet,
    input  logic [FRAME_SIZE-1:0]  ecc_codeword,
    output logic [FRAME_SIZE-1:0]  ecc_frame,
    output logic [PACKET_SIZE-1:0] ecc_data,
    output logic                   ecc_irq,
    output logic                   ecc_correct
);

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_PRIO = 2'd1;
    localparam logic [1:0] ARB_NORM = 2'd2;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  arb_state;
    logic [1:0]  arb_next;
    logic [15:0] timer_count;
    logic        timer_armed;

    always_comb begin
        arb_next = arb_state;
        case (arb_state)
            ARB_IDLE: begin
                if (in_priority)    arb_next = ARB_PRIO;
                else if (in_normal) arb_next = ARB_NORM;
            end
            ARB_PRIO: if (!in_priority) arb_next = ARB_IDLE;
            ARB_NORM: if (!in_normal)   arb_next = ARB_IDLE;
            default:  arb_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) arb_state <= ARB_IDLE;
        else        arb_state <= arb_next;
    end

    assign out_priority = (arb_state == ARB_PRIO);
    assign out_normal   = (arb_state == ARB_NORM);

    // count holds the number of cycles since restart was last seen high
    always_ff @(posedge clock) begin
        if (!reset) begin
            timer_count <= '0;
            timer_armed <= 1'b0;
            timeout     <= 1'b0;
        end else if (timer_restart) begin
            timer_count <= '0;
            timer_armed <= 1'b1;
            timeout     <= 1'b0;
        end else if (timer_armed) begin
            if (timer_count == TIMER_LAST) begin
                timer_count <= '0;
                timer_armed <= 1'b0;
                timeout     <= 1'b1;
            end else begin
                timer_count <= timer_count + 16'd1;
                timeout     <= 1'b0;
            end
        end else begin
            timeout <= 1'b0;
        end
    end

    hamming15_codec u_codec (
        .clock     (clock),
        .reset     (reset),
        .start     (ecc_start),
        .operation (ecc_operation),
        .packet    (ecc_packet),
        .codeword  (ecc_codeword),
        .frame     (ecc_frame),
        .data      (ecc_data),
        .irq       (ecc_irq),
        .correct   (ecc_correct)
    );

endmodule

// File: tb/tb_link_ctrl_unit.sv
// Self-checking bench for link_ctrl_unit: rule-level reference model compared
// every cycle, plus directed vectors with literal expected values.
module tb_link_ctrl_unit;
    import link_pkg::*;

    localparam int T = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_priority = 1'b0, in_normal = 1'b0;
    logic        out_priority, out_normal;
    logic        timer_restart = 1'b0;
    logic        timeout;
    logic        ecc_start = 1'b0, ecc_operation = 1'b0;
    logic [10:0] ecc_packet = '0;
    logic [14:0] ecc_codeword = '0;
    logic [14:0] ecc_frame;
    logic [10:0] ecc_data;
    logic        ecc_irq, ecc_correct;

    int errors = 0;
    int checks = 0;

    logic        e_op = 0, e_on = 0, e_to = 0, e_irq = 0, e_corr = 0;
    logic [14:0] e_frame = '0;
    logic [10:0] e_data = '0;
    logic        m_armed = 0;
    int          m_age = 0;

    always #5 clock = ~clock;

    link_ctrl_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .in_priority(in_priority), .in_normal(in_normal),
        .out_priority(out_priority), .out_normal(out_normal),
        .timer_restart(timer_restart), .timeout(timeout),
        .ecc_start(ecc_start), .ecc_operation(ecc_operation),
        .ecc_packet(ecc_packet), .ecc_codeword(ecc_codeword),
        .ecc_frame(ecc_frame), .ecc_data(ecc_data),
        .ecc_irq(ecc_irq), .ecc_correct(ecc_correct)
    );

    function automatic bit is_pow2(int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [14:0] m_encode(logic [10:0] d);
        logic [14:0] f;
        int j;
        logic par;
        f = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (!is_pow2(pos)) begin
                f[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 15; pos++)
                if (!is_pow2(pos) && pos[k]) par = par ^ f[pos-1];
            f[(1 << k) - 1] = par;
        end
        return f;
    endfunction

    function automatic logic [10:0] m_extract(logic [14:0] f);
        logic [10:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (!is_pow2(pos)) begin
                d[j] = f[pos-1];
                j++;
            end
        end
        return d;
    endfunction

    function automatic bit m_valid(logic [14:0] f);
        return m_encode(m_extract(f)) == f;
    endfunction

    // nearest codeword by brute force over all single-bit flips
    function automatic logic [14:0] m_fix(logic [14:0] f);
        logic [14:0] one;
        if (m_valid(f)) return f;
        for (int i = 0; i < 15; i++) begin
            one = 15'd1 << i;
            if (m_valid(f ^ one)) return f ^ one;
        end
        return f;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            e_op <= 0; e_on <= 0; e_to <= 0; m_armed <= 0; m_age <= 0;
            e_irq <= 0; e_corr <= 0; e_frame <= '0; e_data <= '0;
        end else begin
            e_op <= in_priority && (e_op || !e_on);
            e_on <= in_normal && (e_on || (!e_op && !in_priority));
            if (timer_restart) begin
                m_armed <= 1; m_age <= 0; e_to <= 0;
            end else if (m_armed) begin
                m_age   <= m_age + 1;
                e_to    <= (m_age + 1 == T);
                m_armed <= (m_age + 1 != T);
            end else begin
                e_to <= 0;
            end
            e_irq <= ecc_start;
            if (ecc_start) begin
                if (ecc_operation) begin
                    e_data <= m_extract(m_fix(ecc_codeword));
                    e_corr <= m_valid(ecc_codeword);
                end else begin
                    e_frame <= m_encode(ecc_packet);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("model out_priority", 32'(out_priority), 32'(e_op));
        chk("model out_normal", 32'(out_normal), 32'(e_on));
        chk("model timeout", 32'(timeout), 32'(e_to));
        chk("model ecc_irq", 32'(ecc_irq), 32'(e_irq));
        chk("model ecc_frame", 32'(ecc_frame), 32'(e_frame));
        chk("model ecc_data", 32'(ecc_data), 32'(e_data));
        chk("model ecc_correct", 32'(ecc_correct), 32'(e_corr));
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic codec_op(input logic op, input logic [10:0] pkt, input logic [14:0] cw);
        ecc_operation = op;
        ecc_packet    = pkt;
        ecc_codeword  = cw;
        ecc_start     = 1'b1;
        cyc();
        ecc_start = 1'b0;
    endtask

    initial begin
        logic [14:0] cw;
        logic [10:0] pkt;

        cyc(); cyc();
        chk("reset out_priority", 32'(out_priority), 0);
        chk("reset out_normal", 32'(out_normal), 0);
        chk("reset timeout", 32'(timeout), 0);
        chk("reset ecc_frame", 32'(ecc_frame), 0);
        chk("reset ecc_irq", 32'(ecc_irq), 0);
        reset = 1'b1;
        cyc();

        // both requests from idle, then priority released
        in_priority = 1; in_normal = 1; cyc();
        chk("arb1 prio", 32'(out_priority), 1);
        chk("arb1 norm", 32'(out_normal), 0);
        in_priority = 0; cyc();
        chk("arb1 gap prio", 32'(out_priority), 0);
        chk("arb1 gap norm", 32'(out_normal), 0);
        cyc();
        chk("arb1 norm after", 32'(out_normal), 1);
        in_normal = 0; cyc();
        chk("arb1 norm drop", 32'(out_normal), 0);

        // normal held, priority arrives: no preemption
        in_normal = 1; cyc();
        chk("arb2 norm", 32'(out_normal), 1);
        in_priority = 1; cyc(); cyc();
        chk("arb2 norm held", 32'(out_normal), 1);
        chk("arb2 prio wait", 32'(out_priority), 0);
        in_normal = 0; cyc();
        chk("arb2 norm drop", 32'(out_normal), 0);
        chk("arb2 prio idle", 32'(out_priority), 0);
        cyc();
        chk("arb2 prio rise", 32'(out_priority), 1);
        in_priority = 0; cyc();
        chk("arb2 prio drop", 32'(out_priority), 0);

        // single restart: pulse only at cycle 8
        timer_restart = 1; cyc(); timer_restart = 0;
        for (int k = 1; k <= 28; k++) begin
            cyc();
            chk($sformatf("tmr1 k=%0d", k), 32'(timeout), 32'(k == 8));
        end

        // re-restart at cycle 5 moves pulse to cycle 13
        timer_restart = 1; cyc(); timer_restart = 0;
        for (int k = 1; k <= 4; k++) cyc();
        timer_restart = 1; cyc(); timer_restart = 0;
        for (int k = 6; k <= 25; k++) begin
            cyc();
            chk($sformatf("tmr2 k=%0d", k), 32'(timeout), 32'(k == 13));
        end

        // restart coinciding with expiry suppresses the pulse
        timer_restart = 1; cyc(); timer_restart = 0;
        for (int k = 1; k <= 7; k++) cyc();
        timer_restart = 1; cyc(); timer_restart = 0;
        chk("tmr3 expiry restart", 32'(timeout), 0);
        for (int k = 9; k <= 20; k++) begin
            cyc();
            chk($sformatf("tmr3 k=%0d", k), 32'(timeout), 32'(k == 16));
        end

        // restart held for three cycles: count measured from the last one
        timer_restart = 1; cyc(); cyc(); cyc(); timer_restart = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("tmr4 k=%0d", k), 32'(timeout), 32'(k == 8));
        end

        codec_op(OP_ENCODE, 11'h001, '0);
        chk("enc 001 frame", 32'(ecc_frame), 32'h0007);
        chk("enc 001 irq", 32'(ecc_irq), 1);
        cyc();
        chk("enc irq one cycle", 32'(ecc_irq), 0);
        chk("enc frame hold", 32'(ecc_frame), 32'h0007);
        codec_op(OP_ENCODE, 11'h000, '0);
        chk("enc 000 frame", 32'(ecc_frame), 32'h0000);
        codec_op(OP_ENCODE, 11'h7FF, '0);
        chk("enc 7ff frame", 32'(ecc_frame), 32'h7FFF);
        codec_op(OP_DECODE, '0, 15'h0017);
        chk("dec 0017 data", 32'(ecc_data), 32'h001);
        chk("dec 0017 correct", 32'(ecc_correct), 0);
        chk("dec frame unchanged", 32'(ecc_frame), 32'h7FFF);
        codec_op(OP_DECODE, '0, 15'h0007);
        chk("dec 0007 data", 32'(ecc_data), 32'h001);
        chk("dec 0007 correct", 32'(ecc_correct), 1);

        // back-to-back starts
        ecc_start = 1; ecc_operation = OP_ENCODE;
        for (int k = 0; k < 3; k++) begin
            ecc_packet = 11'(11'h155 + k);
            cyc();
            chk("b2b irq", 32'(ecc_irq), 1);
        end
        ecc_start = 0; cyc();
        chk("b2b irq end", 32'(ecc_irq), 0);

        for (int k = 0; k < 30; k++) begin
            pkt = 11'($urandom_range(0, 2047));
            codec_op(OP_ENCODE, pkt, '0);
            cw = m_encode(pkt);
            if (k % 4 != 0) cw[$urandom_range(0, 14)] ^= 1'b1;
            codec_op(OP_DECODE, '0, cw);
            chk("rand dec data", 32'(ecc_data), 32'(pkt));
        end

        // reset mid-activity
        in_normal = 1; cyc(); cyc();
        chk("rst pre norm", 32'(out_normal), 1);
        timer_restart = 1; cyc(); timer_restart = 0; cyc();
        ecc_operation = OP_DECODE; ecc_codeword = 15'h0017; ecc_start = 1; cyc();
        reset = 0; in_normal = 0; cyc();
        chk("rst norm", 32'(out_normal), 0);
        chk("rst prio", 32'(out_priority), 0);
        chk("rst irq", 32'(ecc_irq), 0);
        chk("rst data", 32'(ecc_data), 0);
        chk("rst frame", 32'(ecc_frame), 0);
        chk("rst correct", 32'(ecc_correct), 0);
        ecc_start = 0; reset = 1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("post rst timeout", 32'(timeout), 0);
            chk("post rst irq", 32'(ecc_irq), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
